sync_detector_acq: RTL and testbench
====================================

Name: sync_detector_acq

Overview:
- Acquisition stage that sits directly downstream of the sine excitation generator.
- Consumes the generator's conversion-request, period-start and half-cycle phase strobes, and drives an external serial ADC (CONVST/CS_N/SCLK/SDO).
- Captures one sample per request and demodulates it synchronously: the sample is added in the positive half-cycle and subtracted in the negative half-cycle.
- Publishes one accumulated result per excitation period.

Parameters:
ADC_BITS, 12, ADC word width; offset-binary, MSB first
SCLK_DIV, 4, clk cycles per SCLK half-period (min 1)
CONV_CYCLES, 40, clk cycles from CONV start to READ start (min 3)
ACC_W, 24, signed accumulator/result width (min ADC_BITS+2)

Ports:
clk  in  1  system clock, single domain
rst  in  1  synchronous, active-high reset
enable  in  1  1 = accept new requests and period edges
conv_req  in  1  level from generator; rising edge requests a conversion
period_start  in  1  level from generator; rising edge marks a new excitation period
phase_neg  in  1  1 = current sample lies in the negative half-cycle
adc_sdo  in  1  ADC serial data
adc_convst  out  1  ADC conversion start
adc_cs_n  out  1  ADC chip select, active low
adc_sclk  out  1  ADC serial clock
sample  out  ADC_BITS  last captured raw word
sample_valid  out  1  one-cycle pulse: sample updated
result  out  ACC_W  signed demodulated sum of the completed period
result_valid  out  1  one-cycle pulse: result updated
overrun  out  1  sticky flag: a request arrived while busy

Behaviour:
- Reset values (synchronous, rst=1 at a clk edge):
  - adc_convst=0, adc_cs_n=1, adc_sclk=0.
  - sample=0, sample_valid=0, result=0, result_valid=0, overrun=0.
  - Accumulator=0, armed=0, FSM=IDLE, edge-detect history regs=0.
- rst=1 in any state aborts immediately. No sample_valid or result_valid is produced for the aborted operation.
- Edge detect: req_edge = conv_req & ~conv_req_d; per_edge = period_start & ~period_start_d. History regs update every cycle regardless of enable.
- When enable=0, both edges are ignored. A conversion already in flight completes and still accumulates.
- FSM states:
  - IDLE: on req_edge (cycle T0), latch phase_neg into ph; next state CONV at T0+1.
  - CONV:
    - adc_convst=1 for the first 2 cycles of CONV, then 0.
    - Stay in CONV for CONV_CYCLES cycles, then go to READ.
  - READ:
    - adc_cs_n=0 for exactly ADC_BITS*2*SCLK_DIV cycles.
    - adc_sclk starts at 0 and toggles every SCLK_DIV cycles.
    - adc_sdo is sampled on the cycle adc_sclk goes 0->1 and shifted in MSB first.
    - adc_sclk returns to 0 and adc_cs_n to 1 on the READ->DONE transition.
  - DONE (1 cycle): sample <= shift reg; sample_valid=1; accumulate; go to IDLE.
- Latency: sample_valid is asserted at T0+1+CONV_CYCLES+ADC_BITS*2*SCLK_DIV. With defaults this is T0+137.
- A req_edge arriving in DONE or IDLE on the same cycle that DONE completes is accepted only in IDLE. Requests arriving in DONE are overruns.
- Overrun: req_edge with enable=1 while FSM != IDLE sets overrun=1. The request is dropped. overrun is cleared only by rst.
- Arithmetic:
  - Signed sample s = sample - 2^(ADC_BITS-1), sign-extended to ACC_W.
  - acc <= acc + s if ph=0, acc - s if ph=1.
  - Saturating: clamp to [-(2^(ACC_W-1)), 2^(ACC_W-1)-1]. No wrap.
- Period handling, on per_edge with enable=1:
  - If armed=1: result <= acc; result_valid=1 for one cycle.
  - acc <= 0 in either case; armed <= 1.
  - The first period edge after reset only arms and produces no result.
- Simultaneous DONE and per_edge:
  - The completed sample belongs to the new period: result takes acc before this sample.
  - acc <= ±s (saturated), not 0.
- enable falling clears armed. The next accepted period edge re-arms without emitting a result.

Test Plan:
- Reset: hold rst=1 for 3 cycles with random inputs -> all outputs at reset values, adc_cs_n=1, no pulses.
- Single conversion: req_edge at T0, adc_sdo drives 0xA5C MSB first on sclk rises.
  - Required: adc_convst high T0+1..T0+2.
  - adc_cs_n low for 96 cycles with exactly 12 sclk rises.
  - sample=0xA5C and sample_valid at T0+137 only.
- Demodulation:
  - Stimulus: per_edge (arm); then samples 0xC00 with ph=0, 0xC00 with ph=0, 0x400 with ph=1; then per_edge.
  - Required: result=+3072 with a single result_valid pulse; the arming edge gave no result_valid.
- Overrun: second req_edge 50 cycles after the first -> overrun=1 stays set, exactly one sample_valid, FSM idles normally after.
- Saturation: ACC_W=14, five samples of 0xFFF with ph=0 and armed, then per_edge -> result=8191, not wrapped.
- Abort/enable:
  - rst pulsed mid-READ -> next cycle adc_cs_n=1, adc_sclk=0, no sample_valid.
  - enable=0 with req_edge -> no adc_convst activity.
  - DONE coincident with per_edge -> result excludes that sample and the next result includes it.

Source files
------------

// File: rtl/sync_detector_acq_if.sv
// sync_detector_acq_if: serial ADC pins (CONVST/CS_N/SCLK/SDO) between the acquisition stage and the converter
interface sync_detector_acq_if;
    logic adc_convst;
    logic adc_cs_n;
    logic adc_sclk;
    logic adc_sdo;
    modport master (output adc_convst, adc_cs_n, adc_sclk, input adc_sdo);
    modport slave (input adc_convst, adc_cs_n, adc_sclk, output adc_sdo);
endinterface

// File: rtl/sync_detector_acq.sv
// sync_detector_acq: serial ADC acquisition with synchronous +/- demodulation and per-period saturating accumulation
module sync_detector_acq #(
    parameter int ADC_BITS    = 12,
    parameter int SCLK_DIV    = 4,
    parameter int CONV_CYCLES = 40,
    parameter int ACC_W       = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    conv_req,
    input  logic                    period_start,
    input  logic                    phase_neg,
    sync_detector_acq_if.master     adc,
    output logic [ADC_BITS-1:0]     sample,
    output logic                    sample_valid,
    output logic signed [ACC_W-1:0] result,
    output logic                    result_valid,
    output logic                    overrun
);
    localparam int CW = $clog2(CONV_CYCLES);
    localparam int DW = $clog2(SCLK_DIV) + 1;
    localparam int HW = $clog2(2 * ADC_BITS);
    localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(2 * ADC_BITS - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CONV, READ, DONE} state_t;
    state_t state, state_n;

    logic conv_req_d, period_start_d, enable_d, ph, armed, sclk;
    logic req_ok, per_ok, rise, read_end;
    logic [CW-1:0] cnt;
    logic [DW-1:0] div;
    logic [HW-1:0] half;
    logic [ADC_BITS-1:0] shreg, sh_next;
    logic signed [ACC_W-1:0] acc, s_ext, base, acc_n;
    logic signed [ACC_W:0] sum;

    assign adc.adc_sclk = sclk;

    always_comb begin
        req_ok         = conv_req & ~conv_req_d & enable;
        per_ok         = period_start & ~period_start_d & enable;
        rise           = state == READ && sclk && div == '0;
        read_end       = state == READ && div == DIV_LAST && half == HALF_LAST;
        sh_next        = rise ? {shreg[ADC_BITS-2:0], adc.adc_sdo} : shreg;
        state_n        = (state == IDLE && req_ok) ? CONV :
                         (state == CONV && cnt == CONV_LAST) ? READ :
                         read_end ? DONE :
                         (state == DONE) ? IDLE : state;
        adc.adc_convst = state == CONV && cnt < CW'(2);
        adc.adc_cs_n   = state != READ;
        // offset binary -> two's complement by inverting the MSB
        s_ext          = ACC_W'($signed({~sample[ADC_BITS-1], sample[ADC_BITS-2:0]}));
        // a sample finishing on a period edge starts the new period's sum
        base           = per_ok ? '0 : acc;
        sum            = {base[ACC_W-1], base} + (ph ? -{s_ext[ACC_W-1], s_ext} : {s_ext[ACC_W-1], s_ext});
        acc_n          = (sum[ACC_W] == sum[ACC_W-1]) ? sum[ACC_W-1:0] : (sum[ACC_W] ? ACC_MIN : ACC_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            conv_req_d     <= 1'b0;
            period_start_d <= 1'b0;
            enable_d       <= 1'b0;
            cnt            <= '0;
            div            <= '0;
            half           <= '0;
            sclk           <= 1'b0;
            shreg          <= '0;
            ph             <= 1'b0;
            sample         <= '0;
            sample_valid   <= 1'b0;
            result         <= '0;
            result_valid   <= 1'b0;
            overrun        <= 1'b0;
            armed          <= 1'b0;
            acc            <= '0;
        end else begin
            state          <= state_n;
            conv_req_d     <= conv_req;
            period_start_d <= period_start;
            enable_d       <= enable;
            cnt            <= (state == CONV) ? cnt + 1'b1 : '0;
            div            <= (state == READ && !read_end && div != DIV_LAST) ? div + 1'b1 : '0;
            half           <= (state != READ || read_end) ? '0 : (div == DIV_LAST) ? half + 1'b1 : half;
            sclk           <= (state != READ || read_end) ? 1'b0 : (div == DIV_LAST) ? ~sclk : sclk;
            shreg          <= sh_next;
            sample_valid   <= read_end;
            sample         <= read_end ? sh_next : sample;
            ph             <= (state == IDLE && req_ok) ? phase_neg : ph;
            overrun        <= overrun | (req_ok && state != IDLE);
            result_valid   <= per_ok && armed;
            result         <= (per_ok && armed) ? acc : result;
            armed          <= per_ok | (armed & ~(enable_d & ~enable));
            acc            <= (state == DONE) ? acc_n : per_ok ? '0 : acc;
        end
    end
endmodule

// File: tb/tb_sync_detector_acq.sv
// tb_sync_detector_acq: directed checks of ADC timing, demodulation, overrun, saturation, enable and abort
module tb_sync_detector_acq;
    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, conv_req = 1'b0, period_start = 1'b0, phase_neg = 1'b0;
    logic [11:0] adc_word = '0;
    int idx = 11;
    int errors = 0, checks = 0;
    logic [11:0] sample_a, sample_b;
    logic sv_a, sv_b, rv_a, rv_b, ov_a, ov_b;
    logic signed [23:0] result_a;
    logic signed [13:0] result_b;

    sync_detector_acq_if bus_a ();
    sync_detector_acq_if bus_b ();

    sync_detector_acq dut_a (
        .clk(clk), .rst(rst), .enable(enable), .conv_req(conv_req), .period_start(period_start),
        .phase_neg(phase_neg), .adc(bus_a), .sample(sample_a), .sample_valid(sv_a),
        .result(result_a), .result_valid(rv_a), .overrun(ov_a)
    );

    sync_detector_acq #(.ACC_W(14)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .conv_req(conv_req), .period_start(period_start),
        .phase_neg(phase_neg), .adc(bus_b), .sample(sample_b), .sample_valid(sv_b),
        .result(result_b), .result_valid(rv_b), .overrun(ov_b)
    );

    always #5 clk = ~clk;

    // ADC model: MSB presented at CS_N fall, next bit after each SCLK fall
    always @(posedge bus_a.adc_cs_n or negedge bus_a.adc_sclk) idx = bus_a.adc_cs_n ? 11 : idx - 1;
    assign bus_a.adc_sdo = (idx >= 0 && idx <= 11) ? adc_word[idx[3:0]] : 1'b0;
    assign bus_b.adc_sdo = bus_a.adc_sdo;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic convert(input logic [11:0] w, input logic ph);
        int n;
        adc_word = w;
        phase_neg = ph;
        conv_req = 1'b1;
        step();
        conv_req = 1'b0;
        n = 1;
        while (sv_a !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        chk("latency", 64'(n), 64'd137);
        chk("sample", 64'(sample_a), 64'(w));
    endtask

    initial begin
        int cv, cvf, cs, rises, sv, sva, n;
        logic prev;
        logic [11:0] svs;
        for (int i = 0; i < 3; i++) begin
            enable = 1'($urandom);
            conv_req = 1'($urandom);
            period_start = 1'($urandom);
            phase_neg = 1'($urandom);
            step();
        end
        chk("rst_convst", 64'(bus_a.adc_convst), 64'd0);
        chk("rst_cs_n", 64'(bus_a.adc_cs_n), 64'd1);
        chk("rst_sclk", 64'(bus_a.adc_sclk), 64'd0);
        chk("rst_sample", 64'(sample_a), 64'd0);
        chk("rst_sv", 64'(sv_a), 64'd0);
        chk("rst_result", 64'(result_a), 64'd0);
        chk("rst_rv", 64'(rv_a), 64'd0);
        chk("rst_overrun", 64'(ov_a), 64'd0);
        rst = 1'b0;
        enable = 1'b1;
        conv_req = 1'b0;
        period_start = 1'b0;
        phase_neg = 1'b0;
        step();
        step();
        // single conversion, cycle-by-cycle
        adc_word = 12'hA5C;
        conv_req = 1'b1;
        cv = 0; cvf = -1; cs = 0; rises = 0; sv = 0; sva = 0; svs = '0; prev = 1'b0;
        for (int c = 1; c <= 140; c++) begin
            step();
            conv_req = 1'b0;
            if (bus_a.adc_convst) begin
                cv++;
                if (cvf < 0) cvf = c;
            end
            if (!bus_a.adc_cs_n) cs++;
            if (bus_a.adc_sclk && !prev) rises++;
            prev = bus_a.adc_sclk;
            if (sv_a) begin
                sv++;
                sva = c;
                svs = sample_a;
            end
        end
        chk("convst_cycles", 64'(cv), 64'd2);
        chk("convst_first", 64'(cvf), 64'd1);
        chk("cs_low_cycles", 64'(cs), 64'd96);
        chk("sclk_rises", 64'(rises), 64'd12);
        chk("sv_count", 64'(sv), 64'd1);
        chk("sv_cycle", 64'(sva), 64'd137);
        chk("sv_sample", 64'(svs), 64'hA5C);
        // demodulation: +1024 +1024 -(-1024)
        period_start = 1'b1;
        step();
        chk("arm_no_rv", 64'(rv_a), 64'd0);
        period_start = 1'b0;
        step();
        convert(12'hC00, 1'b0); step();
        convert(12'hC00, 1'b0); step();
        convert(12'h400, 1'b1); step();
        period_start = 1'b1;
        step();
        chk("demod_rv", 64'(rv_a), 64'd1);
        chk("demod_result", 64'(result_a), 64'd3072);
        period_start = 1'b0;
        step();
        chk("demod_rv_pulse", 64'(rv_a), 64'd0);
        // overrun: second request 50 cycles in, zero-valued samples keep acc at 0
        adc_word = 12'h800;
        phase_neg = 1'b0;
        conv_req = 1'b1;
        step();
        conv_req = 1'b0;
        for (int c = 2; c <= 50; c++) step();
        conv_req = 1'b1;
        sv = 0; sva = 0;
        for (int c = 51; c <= 160; c++) begin
            step();
            conv_req = 1'b0;
            if (sv_a) begin
                sv++;
                sva = c;
            end
        end
        chk("ovr_sv_count", 64'(sv), 64'd1);
        chk("ovr_sv_cycle", 64'(sva), 64'd137);
        chk("ovr_flag", 64'(ov_a), 64'd1);
        convert(12'h800, 1'b0); step();
        chk("ovr_sticky", 64'(ov_a), 64'd1);
        // saturation: 5 x 2047 = 10235 exceeds the 14-bit maximum
        period_start = 1'b1;
        step();
        chk("ovr_period_rv", 64'(rv_a), 64'd1);
        chk("ovr_period_result", 64'(result_a), 64'd0);
        period_start = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            convert(12'hFFF, 1'b0);
            step();
        end
        period_start = 1'b1;
        step();
        chk("sat_wide_result", 64'(result_a), 64'd10235);
        chk("sat_rv", 64'(rv_b), 64'd1);
        chk("sat_result", 64'(result_b), 64'd8191);
        period_start = 1'b0;
        step();
        // period edge coincident with DONE
        convert(12'hC00, 1'b0); step();
        convert(12'h900, 1'b0);
        period_start = 1'b1;
        step();
        chk("coin_rv", 64'(rv_a), 64'd1);
        chk("coin_result", 64'(result_a), 64'd1024);
        period_start = 1'b0;
        step();
        period_start = 1'b1;
        step();
        chk("coin_next_result", 64'(result_a), 64'd256);
        period_start = 1'b0;
        step();
        // disabled requests are ignored; enable fall disarms
        enable = 1'b0;
        step();
        conv_req = 1'b1;
        cv = 0; cs = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            conv_req = 1'b0;
            if (bus_a.adc_convst) cv++;
            if (!bus_a.adc_cs_n) cs++;
        end
        chk("dis_convst", 64'(cv), 64'd0);
        chk("dis_cs", 64'(cs), 64'd0);
        enable = 1'b1;
        step();
        period_start = 1'b1;
        step();
        chk("rearm_no_rv", 64'(rv_a), 64'd0);
        period_start = 1'b0;
        step();
        period_start = 1'b1;
        step();
        chk("rearm_rv", 64'(rv_a), 64'd1);
        chk("rearm_result", 64'(result_a), 64'd0);
        period_start = 1'b0;
        step();
        // abort mid-READ
        conv_req = 1'b1;
        step();
        conv_req = 1'b0;
        n = 0;
        while (bus_a.adc_cs_n && n < 100) begin
            step();
            n++;
        end
        chk("abort_in_read", 64'(bus_a.adc_cs_n), 64'd0);
        repeat (20) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_cs_n", 64'(bus_a.adc_cs_n), 64'd1);
        chk("abort_sclk", 64'(bus_a.adc_sclk), 64'd0);
        chk("abort_sv", 64'(sv_a), 64'd0);
        chk("abort_overrun", 64'(ov_a), 64'd0);
        sv = 0;
        for (int c = 0; c < 200; c++) begin
            step();
            if (sv_a) sv++;
        end
        chk("abort_no_sv", 64'(sv), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
